// File: rtl/arith_unit_seq.sv
// arith_unit_seq: handshaked arithmetic unit.
//   ADD / SUB / SLT finish in one cycle. MUL is a shift-add multiplier that runs
//   for WIDTH cycles and returns the low WIDTH bits of the product. Illegal
//   opcodes return out=0 with illegal=1.
//   Results and flags are registered and held behind a valid/ready handshake.
//
// Optional feature (macro ARITH_SAT_EN): when defined, ADD/SUB saturate on
//   signed overflow instead of wrapping. overflow is still reported.
//
// Handshake: a result transfers on a cycle where out_valid & out_ready are both
//   high. out and the flags stay stable while out_valid=1 and out_ready=0.
//   start is accepted when busy=0, or in a DONE cycle that also completes the
//   output handshake (back-to-back issue).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, opcode, A, B request (opcode 010 ADD, 110 SUB, 111 SLT, 011 MUL)
//   busy                state != IDLE
//   out_valid/out_ready output handshake
//   out, zero, overflow, illegal   registered result and flags
//   state_dbg           current FSM state (0 IDLE, 1 MUL, 2 DONE)
module arith_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  state_t state, next_state;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0] cnt;

  logic             accept, is_mul_op, mul_last;
  logic             op_sub, add_ovf;
  logic [WIDTH-1:0] b_eff, sum;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf, alu_ill;

  assign is_mul_op = (opcode == OP_MUL);
  // A request is taken from IDLE, or from DONE in the same cycle the held
  // result is handed off.
  assign accept    = start & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign mul_last  = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = is_mul_op ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) next_state = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (start) next_state = is_mul_op ? S_MUL : S_DONE;
          else       next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
    state_dbg = state;
  end

  // ---------------- single-cycle ALU ----------------
  // SUB and SLT share the adder as A + ~B + 1; overflow is judged on the
  // operands as the adder sees them, which makes SLT exact at the extremes.
  always_comb begin
    op_sub  = (opcode == OP_SUB) | (opcode == OP_SLT);
    b_eff   = op_sub ? ~B : B;
    sum     = A + b_eff + WIDTH'(op_sub);
    add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
    alu_out = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        alu_ovf = add_ovf;
`ifdef ARITH_SAT_EN
        // On overflow the true result has the sign of A.
        if (add_ovf) alu_out = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        else         alu_out = sum;
`else
        alu_out = sum;
`endif
      end
      OP_SLT:  alu_out = WIDTH'(sum[WIDTH-1] ^ add_ovf);
      OP_MUL:  alu_out = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------- multiplier step ----------------
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // ---------------- datapath / result registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      out      <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      if (is_mul_op) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        out      <= alu_out;
        zero     <= (alu_out == '0);
        overflow <= alu_ovf;
        illegal  <= alu_ill;
      end
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (mul_last) begin
        out      <= acc_next;
        zero     <= (acc_next == '0);
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
module tb_arith_unit_seq;
  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  logic         clk = 1'b0;
  logic         reset, start, out_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a_in, b_in;
  logic         busy, out_valid, zero, overflow, illegal;
  logic [W-1:0] out;
  logic [1:0]   state_dbg;

  // expected entry: {out, zero, overflow, illegal}
  logic [W+2:0] exp_q[$];
  int total_cnt = 0;
  int pass_cnt  = 0;
  int res_idx   = 0;

  arith_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .A(a_in), .B(b_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .overflow(overflow),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Call just after a rising edge. Holds start until the DUT accepts it.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic push, input logic [W-1:0] e_out, input logic e_z,
                      input logic e_ov, input logic e_ill);
    logic acc;
    acc = 1'b0;
    start = 1'b1; opcode = op; a_in = a; b_in = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = !busy || (out_valid && out_ready);
      if (acc && push) exp_q.push_back({e_out, e_z, e_ov, e_ill});
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out, 32'hDEADBEEF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("res%0d_out", res_idx), out, e[W+2:3]);
        check($sformatf("res%0d_zero", res_idx), W'(zero), W'(e[2]));
        check($sformatf("res%0d_ovf", res_idx), W'(overflow), W'(e[1]));
        check($sformatf("res%0d_ill", res_idx), W'(illegal), W'(e[0]));
      end
      res_idx++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_valid;
    logic [W-1:0] ovf_pos, ovf_neg;
`ifdef ARITH_SAT_EN
    ovf_pos = 32'h7FFFFFFF;
    ovf_neg = 32'h80000000;
`else
    ovf_pos = 32'h80000000;
    ovf_neg = 32'h7FFFFFFF;
`endif
    reset = 1'b1; start = 1'b0; opcode = 3'b000; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", W'(busy), 32'd0);
    check("rst_valid", W'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_flags", W'({zero, overflow, illegal}), 32'd0);
    @(posedge clk); #1;

    // ADD latency and busy release
    send(OP_ADD, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("add_latency_valid", W'(out_valid), 32'd1);
    @(negedge clk);
    check("add_busy_released", W'(busy), 32'd0);
    @(posedge clk); #1;

    // directed single-cycle vectors
    send(OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, ovf_pos, 1'b0, 1'b1, 1'b0);
    send(OP_SUB, 32'h80000000, 32'd1, 1'b1, ovf_neg, 1'b0, 1'b1, 1'b0);
    send(OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    send(OP_SLT, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    send(OP_SLT, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    send(OP_SUB, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // MUL latency, with an ignored ADD pulse mid-run
    send(OP_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    first_valid = -1;
    for (int i = 1; i <= 45 && first_valid < 0; i++) begin
      @(negedge clk);
      if (i == 5)  begin start = 1'b1; opcode = OP_ADD; a_in = 32'd1; b_in = 32'd1; end
      if (i == 6)  start = 1'b0;
      if (out_valid) first_valid = i;
    end
    check("mul_latency", W'(first_valid), 32'd33);
    repeat (3) @(posedge clk);
    #1;
    send(OP_MUL, 32'h80000000, 32'd2, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    repeat (36) @(posedge clk);
    #1;

    // output stall, then back-to-back issue
    out_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd20, 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), W'(out_valid), 32'd1);
      check($sformatf("stall%0d_out", i), out, 32'd30);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_valid", W'(out_valid), 32'd1);
    check("b2b_out", out, 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a multiply
    send(OP_MUL, 32'd3, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midmul_rst_busy", W'(busy), 32'd0);
    check("midmul_rst_valid", W'(out_valid), 32'd0);
    check("midmul_rst_out", out, 32'd0);
    repeat (40) @(negedge clk) begin
      if (out_valid) check("midmul_rst_stale_result", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    send(OP_ADD, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
    send(3'b000, 32'd123, 32'd456, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    check("queue_drained", W'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
- Parametrised, handshaked successor to the combinational 32-bit arithmetic unit.
- Executes ADD, SUB and SLT in one cycle.
- Adds an iterative shift-add multiplier (MUL, low WIDTH bits of product).
- Registers results and status flags behind a valid/ready output handshake; sits between the decode stage and the datapath writeback.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, width of the multiplier iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- opcode  input  3  010 ADD, 110 SUB, 111 SLT (signed), 011 MUL; any other value is illegal.
- A  input  WIDTH  operand A, sampled on accepted start.
- B  input  WIDTH  operand B, sampled on accepted start.
- busy  output  1  high while an operation is in progress or a result awaits acceptance.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result when out_valid & out_ready.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- overflow  output  1  signed overflow (ADD/SUB only; otherwise 0).
- illegal  output  1  opcode was not legal; out=0.

Behaviour:
- Reset (sync, active-high): state=IDLE; busy=0, out_valid=0, out=0, zero=0, overflow=0, illegal=0; multiplier counter and accumulator cleared. Reset overrides every other input in the same cycle, including mid-MUL and in DONE; a pending result is discarded.
- States: IDLE, MUL, DONE.
- IDLE:
  - start=0: stay.
  - start=1 with ADD/SUB/SLT/illegal: compute combinationally from A/B, register out and flags, go to DONE. Latency is 1: out_valid is high in the cycle after acceptance.
  - start=1 with MUL: latch A into the multiplicand, B into the multiplier, clear the accumulator and counter, go to MUL.
- MUL: one iteration per cycle for exactly WIDTH cycles.
  - If multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH).
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After iteration WIDTH-1: out = accumulator, overflow=0, then DONE.
  - out_valid first high WIDTH+1 cycles after acceptance.
- DONE: out_valid=1; out and flags held stable until out_valid & out_ready.
  - On handshake with start=0: go to IDLE.
  - On handshake with start=1: accept the new op in the same cycle (back-to-back) with the same transitions as IDLE.
- busy = (state != IDLE). start while busy=1 is ignored, except in a DONE handshake cycle. Operands are not captured while ignored.
- Arithmetic:
  - SUB = A + ~B + 1 (two's complement, carry discarded).
  - ADD/SUB overflow = (sign of the operands as seen by the adder are equal) & (result sign differs).
  - SLT: out = {WIDTH-1 zeros, (A<B signed)}, computed as sign(A-B) XOR overflow(A-B), so it is correct at the extremes.
- zero is computed from the registered out.
- Illegal opcode: out=0, illegal=1, zero=1, latency 1.
- out and flags change only on acceptance or reset; never while out_valid=1 and out_ready=0.

Optional Feature:
- Macro ARITH_SAT_EN.
- Defined: ADD/SUB saturate on signed overflow. Positive overflow gives out = 2^(WIDTH-1)-1; negative overflow gives out = -2^(WIDTH-1). overflow is still reported as 1. SLT and MUL are unaffected.
- Undefined: ADD/SUB wrap modulo 2^WIDTH. No saturation logic is generated.

Test Plan:
- WIDTH=32, ADD A=5 B=7, out_ready=1: out_valid high the cycle after start, out=12, zero=0, overflow=0, busy low next cycle.
- SUB A=3 B=5 -> out=0xFFFFFFFE. ADD A=0x7FFFFFFF B=1 -> out=0x80000000, overflow=1 (with ARITH_SAT_EN: out=0x7FFFFFFF, overflow=1).
- SLT A=0xFFFFFFFF B=1 -> out=1. SLT A=0x80000000 B=0x7FFFFFFF -> out=1. SLT A=1 B=0xFFFFFFFF -> out=0. SUB A=9 B=9 -> out=0, zero=1.
- MUL A=0x0000FFFF B=0x00010001 -> out=0xFFFFFFFF exactly 33 cycles after acceptance. A start pulse with ADD during MUL is ignored (no extra result). MUL A=0x80000000 B=2 -> out=0.
- out_ready=0 for 5 cycles in DONE: out and out_valid held. Then out_ready=1 with start=1 (ADD 1+1): next cycle out=2, out_valid=1, no IDLE bubble.
- reset asserted mid-MUL (cycle 10): next cycle busy=0, out_valid=0, out=0. A fresh ADD 2+2 afterwards returns 4. opcode=000 -> illegal=1, out=0.
